// File: rtl/rom_scan_reader_if.sv
// Scan-reader bundle: scan request/status, synchronous ROM read port and captured-word stream.
// master = reader side, slave = environment side (ROM plus consumer).
interface rom_scan_reader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
);

  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [ADDR_W-1:0] end_addr;
  logic              rom_read_enable;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [DATA_W-1:0] data_out;
  logic [ADDR_W-1:0] data_addr;
  logic              data_valid;
  logic              data_ready;
  logic              busy;
  logic              done;
  logic [7:0]        checksum;

  modport master (
    input  start, start_addr, end_addr, rom_data, data_ready,
    output rom_read_enable, rom_addr, data_out, data_addr, data_valid,
           busy, done, checksum
  );

  modport slave (
    output start, start_addr, end_addr, rom_data, data_ready,
    input  rom_read_enable, rom_addr, data_out, data_addr, data_valid,
           busy, done, checksum
  );

endinterface

// File: rtl/rom_scan_reader.sv
// Scans an inclusive, wrapping ROM address range one word per 3 cycles; data_valid 3 cycles after start.
// A word is held stable in HOLD until data_ready; the scan stalls there with no further ROM reads.
module rom_scan_reader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  rom_scan_reader_if.master   bus
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] ISSUE = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam int EXT_W = (DATA_W > 8) ? DATA_W : 8;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] data_out_q;
  logic [ADDR_W-1:0] data_addr_q;
  logic              data_valid_q;
  logic [7:0]        checksum_q;
  logic [EXT_W-1:0]  word_wide;
  logic [7:0]        word_ext;
  logic              last_word;

  // Checksum is mod 256, so only the low byte of the zero-extended word matters.
  assign word_wide = EXT_W'(bus.rom_data);
  assign word_ext  = word_wide[7:0];
  assign last_word = (cur_addr == last_addr);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    state_nxt = HOLD;
      HOLD:    if (bus.data_ready) state_nxt = last_word ? DONE : ISSUE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cur_addr     <= '0;
      last_addr    <= '0;
      data_out_q   <= '0;
      data_addr_q  <= '0;
      data_valid_q <= 1'b0;
      checksum_q   <= 8'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (bus.start) begin
            cur_addr   <= bus.start_addr;
            last_addr  <= bus.end_addr;
            checksum_q <= 8'd0;
          end
        end
        WAIT: begin
          // The ROM word for cur_addr is on rom_data during this cycle.
          data_out_q   <= bus.rom_data;
          data_addr_q  <= cur_addr;
          checksum_q   <= checksum_q + word_ext;
          data_valid_q <= 1'b1;
        end
        HOLD: begin
          if (bus.data_ready) begin
            data_valid_q <= 1'b0;
            if (!last_word) cur_addr <= cur_addr + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rom_read_enable = (state == ISSUE);
  assign bus.rom_addr        = cur_addr;
  assign bus.data_out        = data_out_q;
  assign bus.data_addr       = data_addr_q;
  assign bus.data_valid      = data_valid_q;
  assign bus.busy            = (state != IDLE);
  assign bus.done            = (state == DONE);
  assign bus.checksum        = checksum_q;

endmodule

// File: tb/tb_rom_scan_reader.sv
// Bench for rom_scan_reader: ROM model returns addr ^ 4'hA one cycle after a strobe; captured words are scoreboarded.
module tb_rom_scan_reader;

  typedef struct packed {
    logic [3:0] addr;
    logic [3:0] data;
  } exp_t;

  typedef struct {
    logic [3:0] sa;
    logic [3:0] ea;
    int         stall;
    int         words;
    int         sum;
    int         busy_cyc;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rom_scan_reader_if #(.ADDR_W(4), .DATA_W(4)) bus ();

  rom_scan_reader #(.ADDR_W(4), .DATA_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always @(posedge clk) begin
    if (bus.rom_read_enable) bus.rom_data <= bus.rom_addr ^ 4'hA;
  end

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  exp_t exp_q[$];
  int   stall_len  = 0;
  bit   hold_ready = 1'b0;

  int         n_words   = 0;
  int         n_strobes = 0;
  int         n_busy    = 0;
  int         n_done    = 0;
  int         stall_cnt = 0;
  bit         held      = 1'b0;
  logic [3:0] snap_d;
  logic [3:0] snap_a;
  exp_t       e;

  // Consumer and scoreboard: samples on the falling edge, drives data_ready for the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      bus.data_ready = 1'b0;
      stall_cnt = 0;
      held = 1'b0;
    end else begin
      if (bus.rom_read_enable) n_strobes++;
      if (bus.busy) n_busy++;
      if (bus.done) n_done++;
      if (bus.data_valid) begin
        if (held) begin
          chk("hold_stable_data", int'(bus.data_out), int'(snap_d));
          chk("hold_stable_addr", int'(bus.data_addr), int'(snap_a));
        end else begin
          snap_d = bus.data_out;
          snap_a = bus.data_addr;
          held = 1'b1;
        end
        if (!hold_ready && stall_cnt >= stall_len) begin
          bus.data_ready = 1'b1;
          stall_cnt = 0;
          held = 1'b0;
          n_words++;
          chk("sb_nonempty", (exp_q.size() > 0) ? 1 : 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_addr", int'(bus.data_addr), int'(e.addr));
            chk("sb_data", int'(bus.data_out), int'(e.data));
          end
        end else begin
          bus.data_ready = 1'b0;
          stall_cnt++;
        end
      end else begin
        bus.data_ready = 1'b0;
        stall_cnt = 0;
        held = 1'b0;
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rom_read_enable"}, int'(bus.rom_read_enable), 0);
    chk({tag, "_rom_addr"},        int'(bus.rom_addr), 0);
    chk({tag, "_data_out"},        int'(bus.data_out), 0);
    chk({tag, "_data_addr"},       int'(bus.data_addr), 0);
    chk({tag, "_data_valid"},      int'(bus.data_valid), 0);
    chk({tag, "_busy"},            int'(bus.busy), 0);
    chk({tag, "_done"},            int'(bus.done), 0);
    chk({tag, "_checksum"},        int'(bus.checksum), 0);
  endtask

  task automatic run_scan(input logic [3:0] sa, input logic [3:0] ea, input int stall,
                          input int exp_words, input int exp_sum, input int exp_busy,
                          input string tag);
    int w0, s0, b0, d0, cyc;
    logic [3:0] a;
    for (int i = 0; i < exp_words; i++) begin
      a = sa + 4'(i);
      exp_q.push_back({a, a ^ 4'hA});
    end
    stall_len = stall;
    @(posedge clk);
    w0 = n_words; s0 = n_strobes; b0 = n_busy; d0 = n_done;
    @(negedge clk);
    bus.start = 1'b1;
    bus.start_addr = sa;
    bus.end_addr = ea;
    @(negedge clk);
    bus.start = 1'b0;
    bus.start_addr = ~sa;
    bus.end_addr = sa;
    cyc = 0;
    while (!bus.done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done_seen"}, int'(bus.done), 1);
    // A start presented during DONE must not launch a scan.
    bus.start = 1'b1;
    bus.start_addr = 4'd9;
    bus.end_addr = 4'd9;
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_start_in_done_ignored"}, int'(bus.busy), 0);
    @(posedge clk);
    chk({tag, "_words"},    n_words - w0, exp_words);
    chk({tag, "_strobes"},  n_strobes - s0, exp_words);
    chk({tag, "_busy_cyc"}, n_busy - b0, exp_busy);
    chk({tag, "_done_cnt"}, n_done - d0, 1);
    chk({tag, "_checksum"}, int'(bus.checksum), exp_sum);
    chk({tag, "_sb_drained"}, exp_q.size(), 0);
    chk({tag, "_valid_idle"}, int'(bus.data_valid), 0);
  endtask

  vec_t tbl[5];

  initial begin
    int cyc, d0, w0;
    logic [3:0] a;

    // REQ-033..036 plus a full wrap starting mid-range; busy = (3+stall)*words + 1 for DONE.
    tbl[0] = '{sa: 4'd0,  ea: 4'd3,  stall: 0, words: 4,  sum: 'h26, busy_cyc: 13};
    tbl[1] = '{sa: 4'd14, ea: 4'd1,  stall: 0, words: 4,  sum: 'h1E, busy_cyc: 13};
    tbl[2] = '{sa: 4'd5,  ea: 4'd5,  stall: 0, words: 1,  sum: 'h0F, busy_cyc: 4};
    tbl[3] = '{sa: 4'd0,  ea: 4'd15, stall: 4, words: 16, sum: 'h78, busy_cyc: 113};
    tbl[4] = '{sa: 4'd7,  ea: 4'd6,  stall: 1, words: 16, sum: 'h78, busy_cyc: 65};

    bus.start = 1'b0;
    bus.start_addr = 4'd0;
    bus.end_addr = 4'd0;
    bus.rom_data = 4'd0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("in_reset");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk_reset_outputs("after_release");

    for (int i = 0; i < 5; i++) begin
      run_scan(tbl[i].sa, tbl[i].ea, tbl[i].stall, tbl[i].words, tbl[i].sum,
               tbl[i].busy_cyc, $sformatf("vec%0d", i));
    end

    // Start pulsed mid-scan with other addresses: scan 2..6 must finish unchanged.
    fork
      run_scan(4'd2, 4'd6, 0, 5, 'h3A, 16, "busy_start");
      begin
        repeat (6) @(negedge clk);
        bus.start = 1'b1;
        bus.start_addr = 4'd9;
        bus.end_addr = 4'd12;
        @(negedge clk);
        bus.start = 1'b0;
      end
    join

    // Reset while the third word of a 0..3 scan sits in HOLD.
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      a = 4'(i);
      exp_q.push_back({a, a ^ 4'hA});
    end
    stall_len = 0;
    hold_ready = 1'b0;
    @(posedge clk);
    d0 = n_done;
    w0 = n_words;
    @(negedge clk);
    bus.start = 1'b1;
    bus.start_addr = 4'd0;
    bus.end_addr = 4'd3;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (n_words - w0 < 2 && cyc < 100) begin
      @(posedge clk);
      cyc++;
    end
    hold_ready = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!bus.data_valid && cyc < 20);
    chk("rst_pre_valid", int'(bus.data_valid), 1);
    chk("rst_pre_addr", int'(bus.data_addr), 2);
    chk("rst_pre_checksum", int'(bus.checksum), 'h1D);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hold_ready = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    chk("rst_no_done", n_done - d0, 0);
    chk_reset_outputs("rst_idle");
    exp_q.delete();
    run_scan(4'd0, 4'd3, 0, 4, 'h26, 13, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no end of test, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rom_scan_reader.md
ROM_SCAN_READER -- requirements
Module: rom_scan_reader

Interface
REQ-001 Parameter ADDR_W, default 4, ROM address width.
REQ-002 Parameter DATA_W, default 4, ROM data width.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port start  input  1  request a scan; sampled only in IDLE.
REQ-006 Port start_addr  input  ADDR_W  first address of scan; latched with start.
REQ-007 Port end_addr  input  ADDR_W  last address of scan, inclusive; latched with start.
REQ-008 Port rom_read_enable  output  1  read strobe to the synchronous ROM.
REQ-009 Port rom_addr  output  ADDR_W  address to the ROM.
REQ-010 Port rom_data  input  DATA_W  ROM registered output; valid one cycle after a strobed read.
REQ-011 Port data_out  output  DATA_W  captured ROM word.
REQ-012 Port data_addr  output  ADDR_W  address of data_out.
REQ-013 Port data_valid  output  1  data_out/data_addr valid; held until accepted.
REQ-014 Port data_ready  input  1  consumer accepts when high with data_valid.
REQ-015 Port busy  output  1  high in every state except IDLE.
REQ-016 Port done  output  1  one-cycle pulse at scan completion.
REQ-017 Port checksum  output  8  running sum mod 256 of words captured in the current scan.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, HOLD, DONE.
REQ-019 IDLE: start=1 -> latch start_addr into cur_addr, end_addr into last_addr, clear checksum, go ISSUE; start=0 -> stay.
REQ-020 ISSUE (one cycle): rom_read_enable=1, rom_addr=cur_addr; next WAIT.
REQ-021 rom_read_enable SHALL be 0 in all states except ISSUE; rom_addr SHALL hold cur_addr in all states.
REQ-022 WAIT (one cycle): on the closing edge data_out<=rom_data, data_addr<=cur_addr, checksum<=checksum+zero-extended rom_data (mod 256), data_valid<=1; next HOLD.
REQ-023 HOLD: data_valid=1, outputs stable; data_ready=0 -> stay; data_ready=1 -> data_valid<=0 and, if cur_addr==last_addr, go DONE, else cur_addr<=cur_addr+1 mod 2^ADDR_W, go ISSUE.
REQ-024 DONE (one cycle): done=1; next IDLE; checksum holds final value until next accepted start or reset.
REQ-025 Word count SHALL be ((end_addr-start_addr) mod 2^ADDR_W)+1; start_addr==end_addr reads exactly one word; end_addr<start_addr wraps through 2^ADDR_W-1 to 0.
REQ-026 start while busy SHALL be ignored; start_addr/end_addr changes after latching SHALL have no effect.
REQ-027 Throughput with data_ready held high: one word per 3 cycles (ISSUE, WAIT, HOLD).
REQ-028 Latency: start sampled at edge N -> rom_read_enable high cycle N+1 -> data_valid high from cycle N+3.
REQ-029 Accepted start in DONE-to-IDLE transition cycle not applicable: start in DONE SHALL be ignored; first acceptable start is in IDLE.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, rom_read_enable=0, rom_addr=0, data_out=0, data_addr=0, data_valid=0, busy=0, done=0, checksum=0, cur_addr=0, last_addr=0.
REQ-031 Reset asserted mid-scan SHALL abort the scan with no done pulse; after release the block waits for a new start.
REQ-032 Outputs SHALL remain at reset values from rst_n release until the first accepted start.

Verification
(Bench ROM model: registered output, rom_data = addr XOR 4'hA one cycle after a strobed read.)
REQ-033 start_addr=0, end_addr=3, data_ready=1 -> words A,B,8,9 at addrs 0..3, done once, checksum=0x26, 12 busy cycles plus DONE.
REQ-034 start_addr=14, end_addr=1 -> addrs 14,15,0,1, words 4,5,A,B, checksum=0x1E.
REQ-035 start_addr=end_addr=5 -> exactly one word 0xF at addr 5, checksum=0x0F, done pulse.
REQ-036 start_addr=0, end_addr=15, data_ready low for 4 cycles on every word -> data_out stable while data_valid, 16 words, checksum=0x78, rom_read_enable pulses exactly 16 times.
REQ-037 start pulsed again during scan with different addrs -> ignored, original scan completes unchanged.
REQ-038 rst_n low during HOLD of third word of 0..3 scan -> all outputs to reset values asynchronously, no done; new scan 0..3 afterward gives checksum=0x26.
